mask_centroid: RTL and testbench

- Consumes the 1-bit per-pixel mask from the colour threshold stage, together with the pixel coordinates delay-matched to that mask.
- Accumulates the x sum, y sum and count of masked pixels over a frame.
- At frame end, computes the integer centroid with sequential dividers.
- Feeds the overlay/tracking logic that places graphics on the detected object.

---
 rtl/centroid_pkg.sv | 19 +
 rtl/seq_divider.sv | 84 ++++++++
 rtl/mask_centroid.sv | 239 +++++++++++++++++++++++
 tb/tb_mask_centroid.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared constants, widths and FSM state type for the mask centroid block.
package centroid_pkg;

  localparam int H_WIDTH_DEF   = 11;
  localparam int V_WIDTH_DEF   = 10;
  localparam int CNT_WIDTH_DEF = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } centroid_state_t;

  // A coordinate sum must hold the largest coordinate times the largest count.
  function automatic int sum_width(input int h_width, input int cnt_width);
    return h_width + cnt_width;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per cycle, WIDTH cycles
// from start_in to a one-cycle done_out pulse. Divisor must be non-zero.
module seq_divider #(
  parameter int WIDTH = 31
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             done_out,
  output logic             busy_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Shift the next dividend bit into the remainder and subtract when it fits.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (start_in) begin
      quo_d  = dividend_in;
      rem_d  = '0;
      dsr_d  = divisor_in;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;
  assign done_out      = done_q;
  assign busy_out      = busy_q;

endmodule

// File: rtl/mask_centroid.sv
// Accumulates masked-pixel coordinate sums over a frame and, on the frame-end
// pulse, divides them by the pixel count to give the integer centroid.
// Optional bounding-box outputs are enabled with MASK_CENTROID_BBOX_EN.
module mask_centroid
  import centroid_pkg::*;
#(
  parameter int H_WIDTH   = H_WIDTH_DEF,
  parameter int V_WIDTH   = V_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [H_WIDTH-1:0] x_in,
  input  logic [V_WIDTH-1:0] y_in,
  input  logic               valid_in,
  input  logic               mask_in,
  input  logic               tabulate_in,
  output logic [H_WIDTH-1:0] x_out,
  output logic [V_WIDTH-1:0] y_out,
  output logic               valid_out,
  output logic               busy_out
`ifdef MASK_CENTROID_BBOX_EN
  ,
  output logic [H_WIDTH-1:0] bbox_xmin_out,
  output logic [H_WIDTH-1:0] bbox_xmax_out,
  output logic [V_WIDTH-1:0] bbox_ymin_out,
  output logic [V_WIDTH-1:0] bbox_ymax_out
`endif
);

  localparam int SUM_W = sum_width(H_WIDTH, CNT_WIDTH);
  localparam int DCW   = $clog2(SUM_W);
  localparam logic [DCW-1:0] LAST_ITER = DCW'(SUM_W - 1);

  logic [SUM_W-1:0]     sum_x_q, sum_x_d, sum_x_inc;
  logic [SUM_W-1:0]     sum_y_q, sum_y_d, sum_y_inc;
  logic [CNT_WIDTH-1:0] count_q, count_d, count_inc;
  logic [SUM_W-1:0]     divisor;
  logic                 pix_take;
  logic                 start_div;

  centroid_state_t      state_q, state_d;
  logic [DCW-1:0]       div_cnt_q, div_cnt_d;
  logic [H_WIDTH-1:0]   x_out_q, x_out_d;
  logic [V_WIDTH-1:0]   y_out_q, y_out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [SUM_W-1:0]     x_quo, y_quo, x_rem, y_rem;
  logic                 x_done, y_done, x_dbusy, y_dbusy;

  // Add the current pixel into the sums unless the count is saturated; a
  // frame-end pulse hands the running totals to the dividers and restarts.
  always_comb begin
    pix_take  = valid_in && mask_in && (count_q != '1);
    sum_x_inc = sum_x_q;
    sum_y_inc = sum_y_q;
    count_inc = count_q;
    if (pix_take) begin
      sum_x_inc = sum_x_q + {{(SUM_W-H_WIDTH){1'b0}}, x_in};
      sum_y_inc = sum_y_q + {{(SUM_W-V_WIDTH){1'b0}}, y_in};
      count_inc = count_q + 1'b1;
    end
    sum_x_d   = tabulate_in ? '0 : sum_x_inc;
    sum_y_d   = tabulate_in ? '0 : sum_y_inc;
    count_d   = tabulate_in ? '0 : count_inc;
    divisor   = {{(SUM_W-CNT_WIDTH){1'b0}}, count_inc};
    start_div = tabulate_in && (state_q == IDLE) && (count_inc != '0);
  end

  // Accumulator registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
      count_q <= '0;
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      count_q <= count_d;
    end
  end

  seq_divider #(.WIDTH(SUM_W)) u_div_x (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_div),
    .dividend_in   (sum_x_inc),
    .divisor_in    (divisor),
    .quotient_out  (x_quo),
    .remainder_out (x_rem),
    .done_out      (x_done),
    .busy_out      (x_dbusy)
  );

  seq_divider #(.WIDTH(SUM_W)) u_div_y (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_div),
    .dividend_in   (sum_y_inc),
    .divisor_in    (divisor),
    .quotient_out  (y_quo),
    .remainder_out (y_rem),
    .done_out      (y_done),
    .busy_out      (y_dbusy)
  );

  // The quotient never exceeds the largest coordinate, so its upper bits and
  // the remainder (floor division) are not needed.
  logic unused_div;
  assign unused_div = ^{x_quo[SUM_W-1:H_WIDTH], y_quo[SUM_W-1:V_WIDTH],
                        x_rem, y_rem, x_dbusy, y_dbusy};

  // Sequence IDLE -> DIVIDE (SUM_W cycles) -> DONE, publishing the quotients
  // with a one-cycle valid pulse; a frame end while busy starts nothing.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_div) begin
          state_d   = DIVIDE;
          div_cnt_d = LAST_ITER;
        end
      end
      DIVIDE: begin
        if (div_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (x_done && y_done) begin
          x_out_d = x_quo[H_WIDTH-1:0];
          y_out_d = y_quo[V_WIDTH-1:0];
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and result registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;

`ifdef MASK_CENTROID_BBOX_EN
  logic [H_WIDTH-1:0] xmin_q, xmin_d, xmin_inc, xmax_q, xmax_d, xmax_inc;
  logic [V_WIDTH-1:0] ymin_q, ymin_d, ymin_inc, ymax_q, ymax_d, ymax_inc;
  logic [H_WIDTH-1:0] lat_xmin_q, lat_xmin_d, lat_xmax_q, lat_xmax_d;
  logic [V_WIDTH-1:0] lat_ymin_q, lat_ymin_d, lat_ymax_q, lat_ymax_d;
  logic [H_WIDTH-1:0] bb_xmin_q, bb_xmin_d, bb_xmax_q, bb_xmax_d;
  logic [V_WIDTH-1:0] bb_ymin_q, bb_ymin_d, bb_ymax_q, bb_ymax_d;

  // Track the extent of masked pixels, hold it alongside the division, and
  // publish it together with the centroid.
  always_comb begin
    xmin_inc = (pix_take && (x_in < xmin_q)) ? x_in : xmin_q;
    xmax_inc = (pix_take && (x_in > xmax_q)) ? x_in : xmax_q;
    ymin_inc = (pix_take && (y_in < ymin_q)) ? y_in : ymin_q;
    ymax_inc = (pix_take && (y_in > ymax_q)) ? y_in : ymax_q;
    xmin_d   = tabulate_in ? '1 : xmin_inc;
    xmax_d   = tabulate_in ? '0 : xmax_inc;
    ymin_d   = tabulate_in ? '1 : ymin_inc;
    ymax_d   = tabulate_in ? '0 : ymax_inc;
    lat_xmin_d = start_div ? xmin_inc : lat_xmin_q;
    lat_xmax_d = start_div ? xmax_inc : lat_xmax_q;
    lat_ymin_d = start_div ? ymin_inc : lat_ymin_q;
    lat_ymax_d = start_div ? ymax_inc : lat_ymax_q;
    bb_xmin_d  = valid_d ? lat_xmin_q : bb_xmin_q;
    bb_xmax_d  = valid_d ? lat_xmax_q : bb_xmax_q;
    bb_ymin_d  = valid_d ? lat_ymin_q : bb_ymin_q;
    bb_ymax_d  = valid_d ? lat_ymax_q : bb_ymax_q;
  end

  // Bounding-box registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      xmin_q     <= '1;
      xmax_q     <= '0;
      ymin_q     <= '1;
      ymax_q     <= '0;
      lat_xmin_q <= '1;
      lat_xmax_q <= '0;
      lat_ymin_q <= '1;
      lat_ymax_q <= '0;
      bb_xmin_q  <= '1;
      bb_xmax_q  <= '0;
      bb_ymin_q  <= '1;
      bb_ymax_q  <= '0;
    end else begin
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
      lat_xmin_q <= lat_xmin_d;
      lat_xmax_q <= lat_xmax_d;
      lat_ymin_q <= lat_ymin_d;
      lat_ymax_q <= lat_ymax_d;
      bb_xmin_q  <= bb_xmin_d;
      bb_xmax_q  <= bb_xmax_d;
      bb_ymin_q  <= bb_ymin_d;
      bb_ymax_q  <= bb_ymax_d;
    end
  end

  assign bbox_xmin_out = bb_xmin_q;
  assign bbox_xmax_out = bb_xmax_q;
  assign bbox_ymin_out = bb_ymin_q;
  assign bbox_ymax_out = bb_ymax_q;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Testbench for mask_centroid: directed frames with hand-computed results plus
// randomized frames, all compared every cycle against a frame-level model.
module tb_mask_centroid;

  localparam int H_WIDTH   = 11;
  localparam int V_WIDTH   = 10;
  localparam int CNT_WIDTH = 20;
  localparam int SUM_W     = H_WIDTH + CNT_WIDTH;
  localparam longint CNT_MAX = (longint'(1) << CNT_WIDTH) - 1;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic [H_WIDTH-1:0] x_in = '0;
  logic [V_WIDTH-1:0] y_in = '0;
  logic               valid_in = 1'b0;
  logic               mask_in = 1'b0;
  logic               tabulate_in = 1'b0;
  logic [H_WIDTH-1:0] x_out;
  logic [V_WIDTH-1:0] y_out;
  logic               valid_out;
  logic               busy_out;
`ifdef MASK_CENTROID_BBOX_EN
  logic [H_WIDTH-1:0] bbox_xmin_out, bbox_xmax_out;
  logic [V_WIDTH-1:0] bbox_ymin_out, bbox_ymax_out;
`endif

  int checks = 0;
  int errors = 0;

  mask_centroid dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .valid_in    (valid_in),
    .mask_in     (mask_in),
    .tabulate_in (tabulate_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .valid_out   (valid_out),
    .busy_out    (busy_out)
`ifdef MASK_CENTROID_BBOX_EN
    ,
    .bbox_xmin_out (bbox_xmin_out),
    .bbox_xmax_out (bbox_xmax_out),
    .bbox_ymin_out (bbox_ymin_out),
    .bbox_ymax_out (bbox_ymax_out)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
    end
  endtask

  // One pixel-cycle of input; returns at the following falling edge.
  task automatic applyStimulus(input logic v, input logic m, input int x, input int y, input logic t);
    valid_in    = v;
    mask_in     = m;
    x_in        = H_WIDTH'(x);
    y_in        = V_WIDTH'(y);
    tabulate_in = t;
    @(negedge clk_in);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic doReset(input int n);
    rst_in = 1'b1;
    idleCycles(n);
    rst_in = 1'b0;
  endtask

  // Returns the 1-based cycle index at which valid_out is seen, or 0.
  task automatic waitForValid(input int limit, output int lat);
    lat = 0;
    for (int n = 1; n <= limit && lat == 0; n++) begin
      if (valid_out) lat = n;
      else idleCycles(1);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit     model_on = 1'b0;
  longint cyc = 0;
  longint m_sx, m_sy, m_cnt;
  longint bstart = -1000;
  longint pend_due = -1;
  int     pend_x, pend_y, cur_x, cur_y;
  int     m_xmin, m_xmax, m_ymin, m_ymax;
  int     pend_xmin, pend_xmax, pend_ymin, pend_ymax;
  int     cur_xmin, cur_xmax, cur_ymin, cur_ymax;

  // Frame accounting at each rising edge: a result is due SUM_W+2 cycles
  // after an accepted frame end; frame ends inside the busy window are lost.
  always @(posedge clk_in) begin
    if (rst_in) begin
      model_on = 1'b1;
      m_sx = 0; m_sy = 0; m_cnt = 0;
      bstart = -1000; pend_due = -1;
      cur_x = 0; cur_y = 0;
      m_xmin = 2047; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
      cur_xmin = 2047; cur_xmax = 0; cur_ymin = 1023; cur_ymax = 0;
    end else if (model_on) begin
      if (valid_in && mask_in && m_cnt < CNT_MAX) begin
        m_sx += longint'(x_in);
        m_sy += longint'(y_in);
        m_cnt++;
        if (int'(x_in) < m_xmin) m_xmin = int'(x_in);
        if (int'(x_in) > m_xmax) m_xmax = int'(x_in);
        if (int'(y_in) < m_ymin) m_ymin = int'(y_in);
        if (int'(y_in) > m_ymax) m_ymax = int'(y_in);
      end
      if (tabulate_in) begin
        if (!(cyc >= bstart + 1 && cyc <= bstart + SUM_W + 1) && m_cnt != 0) begin
          bstart    = cyc;
          pend_x    = int'(m_sx / m_cnt);
          pend_y    = int'(m_sy / m_cnt);
          pend_xmin = m_xmin; pend_xmax = m_xmax;
          pend_ymin = m_ymin; pend_ymax = m_ymax;
          pend_due  = cyc + SUM_W + 2;
        end
        m_sx = 0; m_sy = 0; m_cnt = 0;
        m_xmin = 2047; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
      end
    end
    cyc++;
  end

  // Compare the DUT against the model in the middle of every cycle.
  always @(negedge clk_in) begin
    if (model_on) begin
      if (cyc == pend_due) begin
        cur_x = pend_x; cur_y = pend_y;
        cur_xmin = pend_xmin; cur_xmax = pend_xmax;
        cur_ymin = pend_ymin; cur_ymax = pend_ymax;
      end
      checkOutput("valid_out", longint'(valid_out), longint'(cyc == pend_due));
      checkOutput("busy_out", longint'(busy_out),
                  longint'(cyc >= bstart + 1 && cyc <= bstart + SUM_W + 1));
      checkOutput("x_out", longint'(x_out), longint'(cur_x));
      checkOutput("y_out", longint'(y_out), longint'(cur_y));
`ifdef MASK_CENTROID_BBOX_EN
      checkOutput("bbox_xmin", longint'(bbox_xmin_out), longint'(cur_xmin));
      checkOutput("bbox_xmax", longint'(bbox_xmax_out), longint'(cur_xmax));
      checkOutput("bbox_ymin", longint'(bbox_ymin_out), longint'(cur_ymin));
      checkOutput("bbox_ymax", longint'(bbox_ymax_out), longint'(cur_ymax));
`endif
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with literal expectations, then randomized frames.
  initial begin
    int lat;
    int len;
    doReset(2);
    checkOutput("rst_x", longint'(x_out), 0);
    checkOutput("rst_y", longint'(y_out), 0);
    checkOutput("rst_valid", longint'(valid_out), 0);
    checkOutput("rst_busy", longint'(busy_out), 0);

    $display("[TB] single pixel (100,50)");
    applyStimulus(1'b1, 1'b1, 100, 50, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("t1_busy", longint'(busy_out), 1);
    waitForValid(40, lat);
    checkOutput("t1_latency", lat, 33);
    checkOutput("t1_x", longint'(x_out), 100);
    checkOutput("t1_y", longint'(y_out), 50);
    idleCycles(1);
    checkOutput("t1_busy_after", longint'(busy_out), 0);

    $display("[TB] floor of (0,0),(3,1) with ignored invalid pixel");
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 6, 6, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    waitForValid(40, lat);
    checkOutput("t2_latency", lat, 33);
    checkOutput("t2_x", longint'(x_out), 1);
    checkOutput("t2_y", longint'(y_out), 0);
    idleCycles(2);

    $display("[TB] empty frame");
    applyStimulus(1'b1, 1'b0, 9, 9, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    waitForValid(40, lat);
    checkOutput("t3_no_valid", lat, 0);
    checkOutput("t3_x_hold", longint'(x_out), 1);
    checkOutput("t3_y_hold", longint'(y_out), 0);

    $display("[TB] pixel in the frame-end cycle");
    applyStimulus(1'b1, 1'b1, 10, 20, 1'b1);
    waitForValid(40, lat);
    checkOutput("t4_latency", lat, 33);
    checkOutput("t4_x", longint'(x_out), 10);
    checkOutput("t4_y", longint'(y_out), 20);
    applyStimulus(1'b1, 1'b1, 4, 8, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    waitForValid(40, lat);
    checkOutput("t4_next_x", longint'(x_out), 4);
    checkOutput("t4_next_y", longint'(y_out), 8);

    $display("[TB] frame end while busy");
    applyStimulus(1'b1, 1'b1, 20, 30, 1'b1);
    applyStimulus(1'b1, 1'b1, 50, 50, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    waitForValid(40, lat);
    checkOutput("t5_latency", lat + 5, 33);
    checkOutput("t5_x", longint'(x_out), 20);
    checkOutput("t5_y", longint'(y_out), 30);
    idleCycles(1);
    waitForValid(40, lat);
    checkOutput("t5_no_second", lat, 0);
    applyStimulus(1'b1, 1'b1, 7, 7, 1'b1);
    waitForValid(40, lat);
    checkOutput("t5_x7", longint'(x_out), 7);
    checkOutput("t5_y7", longint'(y_out), 7);

    $display("[TB] reset during division");
    applyStimulus(1'b1, 1'b1, 200, 100, 1'b1);
    idleCycles(9);
    doReset(1);
    waitForValid(40, lat);
    checkOutput("t6_no_valid", lat, 0);
    checkOutput("t6_x", longint'(x_out), 0);
    checkOutput("t6_y", longint'(y_out), 0);
    checkOutput("t6_busy", longint'(busy_out), 0);
    applyStimulus(1'b1, 1'b1, 640, 360, 1'b1);
    waitForValid(40, lat);
    checkOutput("t6_x640", longint'(x_out), 640);
    checkOutput("t6_y360", longint'(y_out), 360);

    $display("[TB] two-pixel frame (5,9),(300,2)");
    applyStimulus(1'b1, 1'b1, 5, 9, 1'b0);
    applyStimulus(1'b1, 1'b1, 300, 2, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    waitForValid(40, lat);
    checkOutput("t7_x", longint'(x_out), 152);
    checkOutput("t7_y", longint'(y_out), 5);
`ifdef MASK_CENTROID_BBOX_EN
    checkOutput("t7_xmin", longint'(bbox_xmin_out), 5);
    checkOutput("t7_xmax", longint'(bbox_xmax_out), 300);
    checkOutput("t7_ymin", longint'(bbox_ymin_out), 2);
    checkOutput("t7_ymax", longint'(bbox_ymax_out), 9);
`endif

    $display("[TB] randomized frames");
    for (int f = 0; f < 30; f++) begin
      len = int'($urandom_range(3, 70));
      for (int p = 0; p < len; p++) begin
        applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0,
                      int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b0);
      end
      applyStimulus(($urandom % 2) == 0, ($urandom % 2) == 0,
                    int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b1);
      if (($urandom % 10) == 0) begin
        idleCycles(int'($urandom_range(1, 30)));
        doReset(1);
      end
      idleCycles(int'($urandom_range(0, 40)));
    end
    idleCycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
